// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a line-refill FSM.
// A lookup is fully combinational against registered valid/tag/data arrays.
// A miss stalls the fetch and pulls one line from memory one beat at a time.
module icache #(
  parameter int WIDTH = 32,
  parameter int LINES = 16,
  parameter int WPL   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_fetch,
  input  logic             inv_all,
  output logic [WIDTH-1:0] instr_fetch,
  output logic             stall_pc,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_rvalid
);

  // state     | meaning
  // ----------+-------------------------------------------------------------
  // S_IDLE    | lookups served; a miss latches the line address and starts a refill
  // S_REFILL  | mem_req held with a stable line address, beats written in order
  // S_FILL_DONE | single stall cycle after the last beat before lookups resume

  localparam int OFF_W    = $clog2(WPL);
  localparam int IDX_W    = $clog2(LINES);
  localparam int LINE_LSB = 2 + OFF_W;
  localparam int TAG_W    = WIDTH - LINE_LSB - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WPL - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REFILL    = 2'd1,
    S_FILL_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              cancel_q, cancel_d;
  logic              mem_req_q, mem_req_d;
  logic [WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [LINES-1:0]  valid_q, valid_d;

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [WIDTH-1:0]  data_q [LINES][WPL];

  logic [OFF_W-1:0]  pc_off;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              beat_fire;
  logic              last_beat;
  logic              unused_bits;

  assign pc_off   = pc_fetch[LINE_LSB-1:2];
  assign pc_idx   = pc_fetch[LINE_LSB+IDX_W-1:LINE_LSB];
  assign pc_tag   = pc_fetch[WIDTH-1:LINE_LSB+IDX_W];

  // The latched refill address doubles as the write pointer for index and tag.
  assign fill_idx = mem_addr_q[LINE_LSB+IDX_W-1:LINE_LSB];
  assign fill_tag = mem_addr_q[WIDTH-1:LINE_LSB+IDX_W];

  assign unused_bits = ^{pc_fetch[1:0], mem_addr_q[LINE_LSB-1:0]};

  assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign beat_fire = (state_q == S_REFILL) && mem_rvalid;
  assign last_beat = beat_fire && (beat_q == LAST_BEAT);

  // Fetch side: only an IDLE hit lets the PC advance; stalled fetches read as zero.
  always_comb begin
    stall_pc    = (state_q != S_IDLE) || !hit;
    instr_fetch = '0;
    if (!stall_pc) begin
      instr_fetch = data_q[pc_idx][pc_off];
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  // Next-state, refill bookkeeping and valid-bit updates.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cancel_d   = cancel_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;

    case (state_q)
      S_IDLE: begin
        if (!hit) begin
          state_d    = S_REFILL;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_fetch[WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
          beat_d     = '0;
          cancel_d   = 1'b0;
        end
      end
      S_REFILL: begin
        // An invalidate mid-refill must not be undone by this line completing.
        if (inv_all) begin
          cancel_d = 1'b1;
        end
        if (beat_fire) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d   = S_FILL_DONE;
            mem_req_d = 1'b0;
            cancel_d  = 1'b0;
          end
        end
      end
      S_FILL_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (inv_all) begin
      valid_d = '0;
    end else if (last_beat && !cancel_q) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  // Control registers with synchronous reset; a reset aborts any refill in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      cancel_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      cancel_q   <= cancel_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Line storage: one data word per accepted beat, tag written with the last beat.
  always_ff @(posedge clk) begin
    if (beat_fire && !rst) begin
      data_q[fill_idx][beat_q] <= mem_rdata;
    end
    if (last_beat && !rst) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: a small responding memory plus per-scenario
// tasks with hand-computed expectations.
module tb_icache;

  logic        clk;
  logic        rst;
  logic [31:0] pc_fetch;
  logic        inv_all;
  logic [31:0] instr_fetch;
  logic        stall_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  int checks;
  int failures;

  logic [31:0] beat_words [4];
  int          r_stall, r_req, r_starts, r_bad, r_leak;
  logic [31:0] r_first;
  bit          r_to;

  icache #(.WIDTH(32), .LINES(16), .WPL(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_fetch    (pc_fetch),
    .inv_all     (inv_all),
    .instr_fetch (instr_fetch),
    .stall_pc    (stall_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input logic [31:0] line);
    for (int i = 0; i < 4; i++) beat_words[i] = mw(line + 32'(4 * i));
  endtask

  // Presents pc and acts as instruction memory until the stall clears.
  // Returns measurements only; callers decide what they should be.
  task automatic run_miss(input logic [31:0] pc, input int gap, input int inv_beat,
                          output int stall_len, output int req_len, output int req_starts,
                          output int addr_bad, output logic [31:0] first_addr,
                          output int leak, output bit timeout);
    int  beats;
    int  cd;
    bit  prev_req;
    bit  got_first;
    pc_fetch = pc; mem_rvalid = 1'b0; inv_all = 1'b0; mem_rdata = '0;
    #1;
    stall_len = 0; req_len = 0; req_starts = 0; addr_bad = 0; leak = 0;
    first_addr = '0; beats = 0; cd = 0; prev_req = 1'b0; got_first = 1'b0;
    while (stall_pc === 1'b1 && stall_len < 200) begin
      stall_len++;
      if (instr_fetch !== 32'h0) leak++;
      if (mem_req === 1'b1) begin
        req_len++;
        if (!prev_req) req_starts++;
        if (!got_first) begin
          first_addr = mem_addr;
          got_first  = 1'b1;
        end else if (mem_addr !== first_addr) begin
          addr_bad++;
        end
        if (cd == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = beat_words[beats % 4];
          if (beats == inv_beat) inv_all = 1'b1;
          beats++;
          cd = gap;
        end else begin
          cd--;
        end
      end
      prev_req = (mem_req === 1'b1);
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0; inv_all = 1'b0; mem_rdata = '0;
      #1;
    end
    timeout = (stall_len >= 200);
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_fetch = 32'h40; inv_all = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    next_cycle();
    next_cycle();
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (instr_fetch !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", instr_fetch); end
    checks++; if (stall_pc !== 1'b1) begin failures++; $display("FAIL reset_stall: got %b want 1", stall_pc); end
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    beat_words[0] = 32'h11; beat_words[1] = 32'h22; beat_words[2] = 32'h33; beat_words[3] = 32'h44;
    run_miss(32'h40, 0, -1, r_stall, r_req, r_starts, r_bad, r_first, r_leak, r_to);
    checks++; if (r_to) begin failures++; $display("FAIL cold_timeout: stall never released"); end
    checks++; if (r_stall != 6) begin failures++; $display("FAIL cold_stall_len: got %0d want 6", r_stall); end
    checks++; if (r_req != 4) begin failures++; $display("FAIL cold_req_len: got %0d want 4", r_req); end
    checks++; if (r_first !== 32'h40) begin failures++; $display("FAIL cold_mem_addr: got %h want 00000040", r_first); end
    checks++; if (r_bad != 0) begin failures++; $display("FAIL cold_addr_stable: got %0d changes want 0", r_bad); end
    checks++; if (r_leak != 0) begin failures++; $display("FAIL cold_instr_zero_on_stall: got %0d nonzero want 0", r_leak); end
    checks++; if (instr_fetch !== 32'h11) begin failures++; $display("FAIL cold_instr: got %h want 00000011", instr_fetch); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL cold_req_drop: got %b want 0", mem_req); end
  endtask

  task automatic test_hit_within_line();
    pc_fetch = 32'h4C;
    #1;
    checks++; if (instr_fetch !== 32'h44) begin failures++; $display("FAIL hit_4c_instr: got %h want 00000044", instr_fetch); end
    checks++; if (stall_pc !== 1'b0) begin failures++; $display("FAIL hit_4c_stall: got %b want 0", stall_pc); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hit_4c_req: got %b want 0", mem_req); end
    pc_fetch = 32'h44;
    #1;
    checks++; if (instr_fetch !== 32'h22) begin failures++; $display("FAIL hit_44_instr: got %h want 00000022", instr_fetch); end
    // A stray beat while idle must not disturb the line.
    pc_fetch = 32'h40; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    checks++; if (instr_fetch !== 32'h11) begin failures++; $display("FAIL stray_beat_instr: got %h want 00000011", instr_fetch); end
    checks++; if (stall_pc !== 1'b0) begin failures++; $display("FAIL stray_beat_stall: got %b want 0", stall_pc); end
  endtask

  task automatic test_conflict();
    load_words(32'h140);
    run_miss(32'h140, 0, -1, r_stall, r_req, r_starts, r_bad, r_first, r_leak, r_to);
    checks++; if (r_first !== 32'h140) begin failures++; $display("FAIL conflict_mem_addr: got %h want 00000140", r_first); end
    checks++; if (r_stall != 6) begin failures++; $display("FAIL conflict_stall_len: got %0d want 6", r_stall); end
    checks++; if (instr_fetch !== mw(32'h140)) begin failures++; $display("FAIL conflict_instr: got %h want %h", instr_fetch, mw(32'h140)); end
    beat_words[0] = 32'h11; beat_words[1] = 32'h22; beat_words[2] = 32'h33; beat_words[3] = 32'h44;
    run_miss(32'h40, 0, -1, r_stall, r_req, r_starts, r_bad, r_first, r_leak, r_to);
    checks++; if (r_stall != 6) begin failures++; $display("FAIL conflict_remiss_stall: got %0d want 6", r_stall); end
    checks++; if (r_first !== 32'h40) begin failures++; $display("FAIL conflict_remiss_addr: got %h want 00000040", r_first); end
    checks++; if (instr_fetch !== 32'h11) begin failures++; $display("FAIL conflict_remiss_instr: got %h want 00000011", instr_fetch); end
  endtask

  task automatic test_gapped();
    load_words(32'h1A0);
    run_miss(32'h1A0, 2, -1, r_stall, r_req, r_starts, r_bad, r_first, r_leak, r_to);
    checks++; if (r_to) begin failures++; $display("FAIL gap_timeout: stall never released"); end
    checks++; if (r_req != 10) begin failures++; $display("FAIL gap_req_len: got %0d want 10", r_req); end
    checks++; if (r_stall != 12) begin failures++; $display("FAIL gap_stall_len: got %0d want 12", r_stall); end
    checks++; if (r_bad != 0) begin failures++; $display("FAIL gap_addr_stable: got %0d changes want 0", r_bad); end
    checks++; if (r_first !== 32'h1A0) begin failures++; $display("FAIL gap_mem_addr: got %h want 000001a0", r_first); end
    for (int i = 0; i < 4; i++) begin
      pc_fetch = 32'h1A0 + 32'(4 * i);
      #1;
      checks++;
      if (instr_fetch !== mw(pc_fetch) || stall_pc !== 1'b0) begin
        failures++;
        $display("FAIL gap_word%0d: got %h stall %b want %h stall 0", i, instr_fetch, stall_pc, mw(pc_fetch));
      end
    end
  endtask

  task automatic test_inv_during_refill();
    load_words(32'h80);
    run_miss(32'h80, 0, 1, r_stall, r_req, r_starts, r_bad, r_first, r_leak, r_to);
    checks++; if (r_starts != 2) begin failures++; $display("FAIL inv_refill_req_starts: got %0d want 2", r_starts); end
    checks++; if (r_stall != 12) begin failures++; $display("FAIL inv_refill_stall_len: got %0d want 12", r_stall); end
    checks++; if (r_req != 8) begin failures++; $display("FAIL inv_refill_req_len: got %0d want 8", r_req); end
    checks++; if (instr_fetch !== mw(32'h80)) begin failures++; $display("FAIL inv_refill_instr: got %h want %h", instr_fetch, mw(32'h80)); end
  endtask

  task automatic test_rst_mid_refill();
    pc_fetch = 32'hC0; mem_rvalid = 1'b0;
    #1;
    checks++; if (stall_pc !== 1'b1) begin failures++; $display("FAIL rstmid_miss: got %b want 1", stall_pc); end
    next_cycle();
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hC0) begin failures++; $display("FAIL rstmid_req: got req %b addr %h want req 1 addr 000000c0", mem_req, mem_addr); end
    mem_rvalid = 1'b1; mem_rdata = 32'hA0;
    next_cycle();
    mem_rdata = 32'hA1;
    next_cycle();
    mem_rdata = 32'hA2; rst = 1'b1;
    next_cycle();
    mem_rdata = 32'hA3;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req_drop: got %b want 0", mem_req); end
    next_cycle();
    rst = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    checks++; if (stall_pc !== 1'b1) begin failures++; $display("FAIL rstmid_line_invalid: got stall %b want 1", stall_pc); end
    load_words(32'hC0);
    run_miss(32'hC0, 0, -1, r_stall, r_req, r_starts, r_bad, r_first, r_leak, r_to);
    checks++; if (r_stall != 6 || r_starts != 1) begin failures++; $display("FAIL rstmid_refetch: got stall %0d starts %0d want 6 1", r_stall, r_starts); end
    checks++; if (instr_fetch !== mw(32'hC0)) begin failures++; $display("FAIL rstmid_instr: got %h want %h", instr_fetch, mw(32'hC0)); end
  endtask

  task automatic test_back_to_back();
    load_words(32'h300);
    run_miss(32'h300, 0, -1, r_stall, r_req, r_starts, r_bad, r_first, r_leak, r_to);
    checks++; if (r_stall != 6 || r_starts != 1) begin failures++; $display("FAIL b2b_first: got stall %0d starts %0d want 6 1", r_stall, r_starts); end
    load_words(32'h310);
    run_miss(32'h31C, 0, -1, r_stall, r_req, r_starts, r_bad, r_first, r_leak, r_to);
    checks++; if (r_first !== 32'h310 || r_stall != 6) begin failures++; $display("FAIL b2b_second: got addr %h stall %0d want 00000310 6", r_first, r_stall); end
    checks++; if (instr_fetch !== mw(32'h31C)) begin failures++; $display("FAIL b2b_second_instr: got %h want %h", instr_fetch, mw(32'h31C)); end
    pc_fetch = 32'h308;
    #1;
    checks++; if (instr_fetch !== mw(32'h308) || stall_pc !== 1'b0) begin failures++; $display("FAIL b2b_first_kept: got %h stall %b want %h stall 0", instr_fetch, stall_pc, mw(32'h308)); end
  endtask

  task automatic test_inv_idle();
    pc_fetch = 32'h304; inv_all = 1'b1;
    #1;
    checks++; if (stall_pc !== 1'b0 || instr_fetch !== mw(32'h304)) begin failures++; $display("FAIL inv_idle_same_cycle: got %h stall %b want %h stall 0", instr_fetch, stall_pc, mw(32'h304)); end
    next_cycle();
    inv_all = 1'b0;
    #1;
    checks++; if (stall_pc !== 1'b1) begin failures++; $display("FAIL inv_idle_cleared: got stall %b want 1", stall_pc); end
    load_words(32'h300);
    run_miss(32'h304, 0, -1, r_stall, r_req, r_starts, r_bad, r_first, r_leak, r_to);
    checks++; if (r_stall != 6 || instr_fetch !== mw(32'h304)) begin failures++; $display("FAIL inv_idle_refill: got stall %0d instr %h want 6 %h", r_stall, instr_fetch, mw(32'h304)); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; pc_fetch = '0; inv_all = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_cold_miss();
    test_hit_within_line();
    test_conflict();
    test_gapped();
    test_inv_during_refill();
    test_rst_mid_refill();
    test_back_to_back();
    test_inv_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
